line_window_gen: RTL and testbench

LINE_WINDOW_GEN -- requirements
Module: line_window_gen

---
 rtl/line_window_gen.sv | 190 +++++++++++++++++++
 tb/tb_line_window_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/line_window_gen.sv
// rtl/line_window_gen.sv - 3x3 sliding window generator over a raster pixel stream
//
// Purpose:
//   Accepts an 8-bit raster-order pixel stream and emits every fully populated
//   3x3 neighbourhood (no border padding), one cycle after the pixel that
//   completes it is accepted. Two line buffers hold the previous two rows;
//   a two-column shift register plus the incoming column forms the window.
//
// Ports:
//   clk            - single clock, rising edge
//   rst_n          - asynchronous active-low reset
//   sof            - current pixel_in is frame pixel (0,0); sampled on accept
//   pixel_in       - 8-bit unsigned pixel
//   pixel_in_valid - pixel_in is valid
//   pixel_in_ready - block can accept a pixel (!window_valid || window_ready)
//   window_out     - 72-bit window, element (r,c) at [8*(3r+c)+7 : 8*(3r+c)]
//   window_valid   - window_out is valid
//   window_ready   - downstream accepts the window
//   win_x, win_y   - window centre column/row (only with WINDOW_COORD_EN)
//
// Configuration macro: WINDOW_COORD_EN adds win_x / win_y outputs.

module line_window_gen #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sof,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_in_valid,
    output logic        pixel_in_ready,
    output logic [71:0] window_out,
    output logic        window_valid,
    input  logic        window_ready
`ifdef WINDOW_COORD_EN
    ,
    output logic [9:0]  win_x,
    output logic [9:0]  win_y
`endif
);

    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [XW-1:0]  r_x;
    logic [YW-1:0]  r_y;
    logic [XW-1:0]  w_x_eff;
    logic [YW-1:0]  w_y_eff;
    logic [XW-1:0]  w_x_nxt;
    logic [YW-1:0]  w_y_nxt;

    logic           w_accept;
    logic           w_last_col;
    logic           w_last_row;
    logic           w_make_win;

    // Line buffers: r_lb1 holds row y-1, r_lb2 holds row y-2 (indexed by column).
    logic [7:0]     r_lb1 [IMG_WIDTH];
    logic [7:0]     r_lb2 [IMG_WIDTH];

    // Shift columns {top, mid, bot}: r_c0 is column x-2, r_c1 is column x-1.
    logic [23:0]    r_c0;
    logic [23:0]    r_c1;
    logic [7:0]     w_top;
    logic [7:0]     w_mid;
    logic [71:0]    w_win_data;

    logic           r_wvalid;
    logic [71:0]    r_wdata;

    assign pixel_in_ready = !r_wvalid || window_ready;
    assign w_accept       = pixel_in_valid && pixel_in_ready;

    // sof overrides the tracked position so the current pixel becomes (0,0).
    assign w_x_eff    = sof ? '0 : r_x;
    assign w_y_eff    = sof ? '0 : r_y;
    assign w_last_col = (w_x_eff == XW'(IMG_WIDTH - 1));
    assign w_last_row = (w_y_eff == YW'(IMG_HEIGHT - 1));
    assign w_make_win = (w_y_eff >= YW'(2)) && (w_x_eff >= XW'(2));

    assign w_top = r_lb2[w_x_eff];
    assign w_mid = r_lb1[w_x_eff];

    // Element 0 (top-left) lands in the low byte, element 8 (bottom-right) in the high byte.
    assign w_win_data = {pixel_in, r_c1[7:0],   r_c0[7:0],
                         w_mid,    r_c1[15:8],  r_c0[15:8],
                         w_top,    r_c1[23:16], r_c0[23:16]};

    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (w_accept) begin
            if (w_last_col) begin
                w_x_nxt = '0;
                w_y_nxt = w_last_row ? '0 : (w_y_eff + YW'(1));
            end else begin
                w_x_nxt = w_x_eff + XW'(1);
                w_y_nxt = w_y_eff;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            if (w_last_col && w_last_row) begin
                w_state_nxt = IDLE;
            end else begin
                case (r_state)
                    IDLE:    w_state_nxt = PRIME;
                    PRIME:   begin
                        if (!sof && (w_x_eff == XW'(2)) && (w_y_eff == YW'(2)))
                            w_state_nxt = ACTIVE;
                    end
                    ACTIVE:  begin
                        // A mid-frame restart has to refill both line buffers.
                        if (sof)
                            w_state_nxt = PRIME;
                    end
                    default: w_state_nxt = IDLE;
                endcase
            end
        end
    end

    // Pixel storage carries no reset; stale contents are never used because
    // windows require two freshly written rows and two freshly shifted columns.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb2[w_x_eff] <= w_mid;
            r_lb1[w_x_eff] <= pixel_in;
            r_c0           <= r_c1;
            r_c1           <= {w_top, w_mid, pixel_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_wvalid <= 1'b0;
            r_wdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            // Accept implies any pending window is leaving this edge, so a
            // new window may overwrite it without loss.
            if (w_accept && w_make_win) begin
                r_wvalid <= 1'b1;
                r_wdata  <= w_win_data;
            end else if (window_ready) begin
                r_wvalid <= 1'b0;
            end
        end
    end

    assign window_out   = r_wdata;
    assign window_valid = r_wvalid;

`ifdef WINDOW_COORD_EN
    logic [9:0] r_win_x;
    logic [9:0] r_win_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_x <= '0;
            r_win_y <= '0;
        end else if (w_accept && w_make_win) begin
            r_win_x <= 10'(w_x_eff) - 10'd1;
            r_win_y <= 10'(w_y_eff) - 10'd1;
        end
    end

    assign win_x = r_win_x;
    assign win_y = r_win_y;
`endif

endmodule

// File: tb/tb_line_window_gen.sv
// tb/tb_line_window_gen.sv - randomized self-checking bench for line_window_gen

module tb_line_window_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sof;
    logic [7:0]  pixel_in;
    logic        pixel_in_valid;
    logic        pixel_in_ready;
    logic [71:0] window_out;
    logic        window_valid;
    logic        window_ready;
`ifdef WINDOW_COORD_EN
    logic [9:0]  win_x;
    logic [9:0]  win_y;
`endif

    always #5 clk = ~clk;

    line_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sof            (sof),
        .pixel_in       (pixel_in),
        .pixel_in_valid (pixel_in_valid),
        .pixel_in_ready (pixel_in_ready),
        .window_out     (window_out),
        .window_valid   (window_valid),
        .window_ready   (window_ready)
`ifdef WINDOW_COORD_EN
        ,
        .win_x          (win_x),
        .win_y          (win_y)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a picture of the frame plus the pending output window.
    logic [7:0]  img [H][W];
    int          mx, my;
    bit          m_valid;
    logic [71:0] m_win;
    int          m_cx, m_cy;
    int          n_out;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [71:0] build(input int y, input int x);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[8*(3*r+c) +: 8] = img[y-2+r][x-2+c];
        return w;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_win   = '0;
        mx      = 0;
        my      = 0;
        m_cx    = 0;
        m_cy    = 0;
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle(input logic v, input logic s, input logic [7:0] p, input logic rdy);
        bit acc, out;
        pixel_in_valid = v;
        sof            = s;
        pixel_in       = p;
        window_ready   = rdy;
        #1;
        check("in_ready", pixel_in_ready, !m_valid || rdy);
        check("win_valid", window_valid, m_valid);
        if (m_valid) begin
            check("win_data", window_out, m_win);
`ifdef WINDOW_COORD_EN
            check("win_x", win_x, m_cx);
            check("win_y", win_y, m_cy);
`endif
        end
        acc = v && (!m_valid || rdy);
        out = m_valid && rdy;
        if (out) n_out++;
        @(posedge clk);
        if (acc) begin
            if (s) begin
                mx = 0;
                my = 0;
            end
            img[my][mx] = p;
            if (my >= 2 && mx >= 2) begin
                m_valid = 1;
                m_win   = build(my, mx);
                m_cx    = mx - 1;
                m_cy    = my - 1;
            end else if (out) begin
                m_valid = 0;
            end
            mx++;
            if (mx == W) begin
                mx = 0;
                my++;
                if (my == H) my = 0;
            end
        end else if (out) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    // Pixels 0..15 with sof on pixel 0 and the sink always ready.
    task automatic ref_frame();
        n_out = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, i == 0, 8'(i), 1'b1);
            if (i == 10) begin
                check("first_win_valid", window_valid, 1);
                check("first_win", window_out, 72'h0a_09_08_06_05_04_02_01_00);
            end
            if (i == 15)
                check("last_win", window_out, 72'h0f_0e_0d_0b_0a_09_07_06_05);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("frame_windows", n_out, 4);
    endtask

    initial begin
        logic [71:0] held;
        rst_n          = 1'b0;
        sof            = 1'b0;
        pixel_in       = '0;
        pixel_in_valid = 1'b0;
        window_ready   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", window_valid, 0);
        check("rst_data", window_out, 0);
        check("rst_ready", pixel_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reference frame, then a frame with no sof (position wrapped to 0,0).
        ref_frame();
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Backpressure: stall 5 cycles after the first window.
        for (int i = 0; i < 11; i++) cycle(1'b1, i == 0, 8'(i + 32), 1'b1);
        held = window_out;
        repeat (5) cycle(1'b1, 1'b0, 8'd43, 1'b0);
        check("stall_hold", window_out, held);
        for (int i = 11; i < 16; i++) cycle(1'b1, 1'b0, 8'(i + 32), 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // sof on pixel 6: window only after ten further pixels.
        for (int i = 0; i < 6; i++) cycle(1'b1, i == 0, 8'(i + 64), 1'b1);
        cycle(1'b1, 1'b1, 8'd70, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 8'(i + 71), 1'b1);
        check("sof_no_win", window_valid, 0);
        cycle(1'b1, 1'b0, 8'd80, 1'b1);
        check("sof_win", window_valid, 1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(i + 81), 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Asynchronous reset while a window is pending.
        for (int i = 0; i < 11; i++) cycle(1'b1, i == 0, 8'(i + 100), 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        pixel_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", window_valid, 0);
        check("async_rst_data", window_out, 0);
        check("async_rst_ready", pixel_in_ready, 1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ref_frame();

        // Random traffic with occasional sof and random backpressure.
        for (int i = 0; i < 4000; i++)
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
                  8'($urandom), $urandom_range(0, 9) < 7);
        repeat (2) cycle(1'b0, 1'b0, 8'h00, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
